// File: rtl/el2_pkg.sv
// Shared types and constants for the LSU exception pipe.
package el2_pkg;

    typedef struct packed {
        logic DCCM_ENABLE;
    } el2_param_t;

    localparam el2_param_t EL2_PARAM_DEFAULT = '{DCCM_ENABLE: 1'b1};

    typedef struct packed {
        logic fast_int;
        logic valid;
        logic load;
        logic store;
        logic dma;
    } el2_lsu_pkt_t;

    typedef struct packed {
        logic        exc_valid;
        logic        inst_type;
        logic        exc_type;
        logic [3:0]  mscause;
        logic [31:0] addr;
    } el2_lsu_error_pkt_t;

    // Payload carried alongside the stage valid bits.
    typedef struct packed {
        logic        store;
        logic        fast_int;
        logic        access;
        logic        misaligned;
        logic        fir_dccm;
        logic        fir_nondccm;
        logic [3:0]  mscause;
        logic [31:0] addr;
    } el2_lsu_stage_t;

    localparam logic [1:0] FIR_NONE    = 2'b00;
    localparam logic [1:0] FIR_DCCM    = 2'b01;
    localparam logic [1:0] FIR_NONDCCM = 2'b10;
    localparam logic [1:0] FIR_ECC     = 2'b11;

endpackage

// File: rtl/el2_lsu_fault_hold.sv
// Sticky first-fault record with a saturating count of faults dropped while full.
module el2_lsu_fault_hold (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        fault_valid,
    input  logic        fault_type,
    input  logic [3:0]  fault_mscause,
    input  logic [31:0] fault_addr,
    input  logic        hold_ack,
    output logic        hold_valid,
    output logic        hold_type,
    output logic [3:0]  hold_mscause,
    output logic [31:0] hold_addr,
    output logic [3:0]  drop_cnt
);

    logic        valid_reg, valid_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        type_reg;
    logic [3:0]  mscause_reg;
    logic [31:0] addr_reg;
    logic        load;

    // An ack frees the record in the same cycle, so a coincident fault is captured.
    assign load = fault_valid & (~valid_reg | hold_ack);

    always_comb begin
        valid_next = valid_reg;
        cnt_next   = cnt_reg;
        if (load) begin
            valid_next = 1'b1;
            cnt_next   = 4'd0;
        end else if (hold_ack) begin
            valid_next = 1'b0;
            cnt_next   = 4'd0;
        end else if (fault_valid && valid_reg && cnt_reg != 4'hF) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid_reg <= 1'b0;
            cnt_reg   <= 4'd0;
        end else begin
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            type_reg    <= fault_type;
            mscause_reg <= fault_mscause;
            addr_reg    <= fault_addr;
        end
    end

    assign hold_valid   = valid_reg;
    assign hold_type    = valid_reg & type_reg;
    assign hold_mscause = valid_reg ? mscause_reg : 4'd0;
    assign hold_addr    = valid_reg ? addr_reg : 32'd0;
    assign drop_cnt     = cnt_reg;

endmodule

// File: rtl/el2_lsu_exc_pipe.sv
// d->m->r pipeline carrying LSU address faults to the r-stage error packet,
// fast-interrupt error code and sticky fault record.
module el2_lsu_exc_pipe
    import el2_pkg::*;
#(
    parameter el2_param_t pt = EL2_PARAM_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_l,
    input  el2_lsu_pkt_t       lsu_pkt_d,
    input  logic               access_fault_d,
    input  logic               misaligned_fault_d,
    input  logic [3:0]         exc_mscause_d,
    input  logic               fir_dccm_access_error_d,
    input  logic               fir_nondccm_access_error_d,
    input  logic [31:0]        start_addr_d,
    input  logic               flush_m_up,
    input  logic               flush_r,
    input  logic               fir_ecc_error_r,
    input  logic               hold_ack,
    output el2_lsu_error_pkt_t lsu_error_pkt_r,
    output logic [1:0]         lsu_fir_error_r,
    output logic               hold_valid,
    output logic               hold_type,
    output logic [3:0]         hold_mscause,
    output logic [31:0]        hold_addr,
    output logic [3:0]         hold_drop_cnt
);

    logic           m_valid_reg, m_valid_next;
    logic           r_valid_reg, r_valid_next;
    el2_lsu_stage_t stage_d, m_stage_reg, r_stage_reg;
    logic           exc_valid;
    logic           fir_active;
    logic           unused_load;

    assign unused_load = lsu_pkt_d.load;

    assign stage_d = '{
        store:       lsu_pkt_d.store,
        fast_int:    lsu_pkt_d.fast_int,
        access:      access_fault_d,
        misaligned:  misaligned_fault_d,
        fir_dccm:    fir_dccm_access_error_d,
        fir_nondccm: fir_nondccm_access_error_d,
        mscause:     exc_mscause_d,
        addr:        start_addr_d
    };

    assign m_valid_next = lsu_pkt_d.valid & ~lsu_pkt_d.dma & ~flush_m_up;
    assign r_valid_next = m_valid_reg & ~flush_m_up;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            m_valid_reg <= 1'b0;
            r_valid_reg <= 1'b0;
        end else begin
            m_valid_reg <= m_valid_next;
            r_valid_reg <= r_valid_next;
        end
    end

    // Payload is only meaningful under its valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (m_valid_next) m_stage_reg <= stage_d;
        if (r_valid_next) r_stage_reg <= m_stage_reg;
    end

    assign exc_valid = r_valid_reg & (r_stage_reg.access | r_stage_reg.misaligned) & ~flush_r;

    always_comb begin
        lsu_error_pkt_r = '0;
        if (exc_valid) begin
            lsu_error_pkt_r.exc_valid = 1'b1;
            lsu_error_pkt_r.inst_type = r_stage_reg.store;
            lsu_error_pkt_r.exc_type  = r_stage_reg.misaligned;
            lsu_error_pkt_r.mscause   = r_stage_reg.mscause;
            lsu_error_pkt_r.addr      = r_stage_reg.addr;
        end
    end

    assign fir_active = r_valid_reg & r_stage_reg.fast_int & ~flush_r;

    always_comb begin
        lsu_fir_error_r = FIR_NONE;
        if (fir_active) begin
            if (fir_ecc_error_r)
                lsu_fir_error_r = FIR_ECC;
            else if (pt.DCCM_ENABLE && r_stage_reg.fir_dccm)
                lsu_fir_error_r = FIR_DCCM;
            else if (r_stage_reg.fir_nondccm)
                lsu_fir_error_r = FIR_NONDCCM;
        end
    end

    el2_lsu_fault_hold u_fault_hold (
        .clk           (clk),
        .rst_l         (rst_l),
        .fault_valid   (exc_valid),
        .fault_type    (r_stage_reg.misaligned),
        .fault_mscause (r_stage_reg.mscause),
        .fault_addr    (r_stage_reg.addr),
        .hold_ack      (hold_ack),
        .hold_valid    (hold_valid),
        .hold_type     (hold_type),
        .hold_mscause  (hold_mscause),
        .hold_addr     (hold_addr),
        .drop_cnt      (hold_drop_cnt)
    );

endmodule
